// File: rtl/pipe_pkg.sv
// Shared writeback types for the pipeline writeback queue and its FIFO.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wn;
    logic [DATA_W-1:0]     d;
  } wb_entry_t;

  typedef enum logic [1:0] {
    OccEmpty,
    OccPartial,
    OccFull
  } occ_e;

endpackage

// File: rtl/pipe_wb_fifo.sv
// Circular buffer of pending MDU writeback entries with occupancy tracking and
// per-slot valid bits so the top can scan queued destinations for hazards.
module pipe_wb_fifo
  import pipe_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LvlW = $clog2(Depth) + 1
) (
  input  logic                                  clk_i,
  input  logic                                  clrn_i,
  input  logic                                  push_i,
  input  wb_entry_t                             wdata_i,
  input  logic                                  pop_i,
  output wb_entry_t                             rdata_o,
  output logic [Depth-1:0][REG_ADDR_W-1:0]      wn_o,
  output logic [Depth-1:0]                      valid_o,
  output logic [LvlW-1:0]                       level_o,
  output logic                                  full_o,
  output logic                                  empty_o
);

  wb_entry_t [Depth-1:0] mem_q;
  logic [Depth-1:0]      valid_q, valid_d;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]       level_q, level_d;
  occ_e                  occ_q;
  logic                  push, pop;

  // Overflow/underflow requests are dropped here so the state stays coherent.
  assign push = push_i & (occ_q != OccFull);
  assign pop  = pop_i & (occ_q != OccEmpty);

  always_comb begin
    valid_d = valid_q;
    if (pop)  valid_d[rd_ptr_q] = 1'b0;
    if (push) valid_d[wr_ptr_q] = 1'b1;
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= '0;
      occ_q    <= OccEmpty;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
      valid_q <= valid_d;
      unique case (occ_q)
        OccEmpty: begin
          if (push) occ_q <= OccPartial;
        end
        OccPartial: begin
          if (level_d == LvlW'(Depth)) occ_q <= OccFull;
          else if (level_d == '0)      occ_q <= OccEmpty;
        end
        OccFull: begin
          if (pop && !push) occ_q <= OccPartial;
        end
        default: occ_q <= OccEmpty;
      endcase
    end
  end

  // Payload storage needs no reset; valid_q qualifies every read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_comb begin
    for (int unsigned i = 0; i < Depth; i++) begin
      wn_o[i] = mem_q[i].wn;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = valid_q;
  assign level_o = level_q;
  assign full_o  = (occ_q == OccFull);
  assign empty_o = (occ_q == OccEmpty);

endmodule

// File: rtl/pipe_wb_queue.sv
// Writeback arbiter merging single-cycle ALU writes with queued MDU results.
// Define PIPE_WB_QUEUE_BYPASS_EN to let MDU results skip an idle, empty FIFO.
module pipe_wb_queue
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 7
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic                       alu_we,
  input  logic [REG_ADDR_W-1:0]      alu_wn,
  input  logic [DATA_W-1:0]          alu_d,
  input  logic                       mdu_valid,
  input  logic [REG_ADDR_W-1:0]      mdu_wn,
  input  logic [DATA_W-1:0]          mdu_d,
  output logic                       mdu_ready,
  output logic                       rf_we,
  output logic [REG_ADDR_W-1:0]      rf_wn,
  output logic [DATA_W-1:0]          rf_d,
  input  logic [REG_ADDR_W-1:0]      rna,
  input  logic [REG_ADDR_W-1:0]      rnb,
  output logic                       hz_a,
  output logic                       hz_b,
  output logic                       drain_req,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  wb_entry_t                        fifo_head;
  wb_entry_t                        fifo_wdata;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] fifo_wn;
  logic [DEPTH-1:0]                 fifo_valid;
  logic                             fifo_full, fifo_empty;
  logic                             mdu_acc, alu_wr, push, pop, bypass;

  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_wn_q, rf_wn_d;
  logic [DATA_W-1:0]     rf_d_q, rf_d_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  drain_q;

  assign mdu_ready = ~fifo_full;
  assign mdu_acc   = mdu_valid & mdu_ready;
  assign alu_wr    = alu_we & (alu_wn != '0);
  assign pop       = ~alu_wr & ~fifo_empty;

`ifdef PIPE_WB_QUEUE_BYPASS_EN
  assign bypass = mdu_acc & (mdu_wn != '0) & fifo_empty & ~alu_wr;
`else
  assign bypass = 1'b0;
`endif

  // Beats to r0 are consumed (ready honoured) but never stored.
  assign push       = mdu_acc & (mdu_wn != '0) & ~bypass;
  assign fifo_wdata = '{wn: mdu_wn, d: mdu_d};

  pipe_wb_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .clrn_i  (clrn),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .wn_o    (fifo_wn),
    .valid_o (fifo_valid),
    .level_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ALU always wins the port, even while a drain is requested.
  always_comb begin
    rf_we_d = 1'b0;
    rf_wn_d = rf_wn_q;
    rf_d_d  = rf_d_q;
    if (alu_wr) begin
      rf_we_d = 1'b1;
      rf_wn_d = alu_wn;
      rf_d_d  = alu_d;
    end else if (pop) begin
      rf_we_d = 1'b1;
      rf_wn_d = fifo_head.wn;
      rf_d_d  = fifo_head.d;
    end else if (bypass) begin
      rf_we_d = 1'b1;
      rf_wn_d = mdu_wn;
      rf_d_d  = mdu_d;
    end
  end

  // A non-empty FIFO that does not pop is necessarily blocked by the ALU.
  always_comb begin
    cnt_d = cnt_q;
    if (fifo_empty || pop) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(STARVE_MAX)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rf_we_q <= 1'b0;
      rf_wn_q <= '0;
      rf_d_q  <= '0;
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      rf_we_q <= rf_we_d;
      rf_wn_q <= rf_wn_d;
      rf_d_q  <= rf_d_d;
      cnt_q   <= cnt_d;
      drain_q <= (cnt_d == CntW'(STARVE_MAX));
    end
  end

  always_comb begin
    hz_a = 1'b0;
    hz_b = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i] && (fifo_wn[i] == rna)) hz_a = 1'b1;
      if (fifo_valid[i] && (fifo_wn[i] == rnb)) hz_b = 1'b1;
    end
    if (rna == '0) hz_a = 1'b0;
    if (rnb == '0) hz_b = 1'b0;
  end

  assign rf_we     = rf_we_q;
  assign rf_wn     = rf_wn_q;
  assign rf_d      = rf_d_q;
  assign drain_req = drain_q;

endmodule

// File: tb/tb_pipe_wb_queue.sv
// Self-checking bench for pipe_wb_queue: directed vector table, corner-case
// sequences, then randomized traffic against a queue-based reference model.
module tb_pipe_wb_queue;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned STARVE_MAX = 7;
  localparam int unsigned LVL_W      = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             clrn;
  logic             alu_we;
  logic [4:0]       alu_wn;
  logic [31:0]      alu_d;
  logic             mdu_valid;
  logic [4:0]       mdu_wn;
  logic [31:0]      mdu_d;
  logic             mdu_ready;
  logic             rf_we;
  logic [4:0]       rf_wn;
  logic [31:0]      rf_d;
  logic [4:0]       rna, rnb;
  logic             hz_a, hz_b, drain_req;
  logic [LVL_W-1:0] level;

  always #5 clk = ~clk;

  pipe_wb_queue #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .alu_we    (alu_we),
    .alu_wn    (alu_wn),
    .alu_d     (alu_d),
    .mdu_valid (mdu_valid),
    .mdu_wn    (mdu_wn),
    .mdu_d     (mdu_d),
    .mdu_ready (mdu_ready),
    .rf_we     (rf_we),
    .rf_wn     (rf_wn),
    .rf_d      (rf_d),
    .rna       (rna),
    .rnb       (rnb),
    .hz_a      (hz_a),
    .hz_b      (hz_b),
    .drain_req (drain_req),
    .level     (level)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    alu_we = 1'b0; alu_wn = '0; alu_d = '0;
    mdu_valid = 1'b0; mdu_wn = '0; mdu_d = '0;
    rna = '0; rnb = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  wn;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          m_cnt;
  logic        m_we;
  logic [4:0]  m_wn;
  logic [31:0] m_d;

  task automatic model_clear();
    mq.delete();
    m_cnt = 0; m_we = 1'b0; m_wn = '0; m_d = '0;
  endtask

  task automatic model_step();
    bit   acc, alu_wr, popped, byp, was_empty;
    ent_t e;
    was_empty = (mq.size() == 0);
    acc       = mdu_valid && (mq.size() < int'(DEPTH));
    alu_wr    = alu_we && (alu_wn != 0);
    popped    = 1'b0;
    byp       = 1'b0;
    m_we      = 1'b0;
    if (alu_wr) begin
      m_we = 1'b1; m_wn = alu_wn; m_d = alu_d;
    end else if (!was_empty) begin
      e = mq.pop_front();
      m_we = 1'b1; m_wn = e.wn; m_d = e.d; popped = 1'b1;
    end
`ifdef PIPE_WB_QUEUE_BYPASS_EN
    else if (acc && mdu_wn != 0) begin
      m_we = 1'b1; m_wn = mdu_wn; m_d = mdu_d; byp = 1'b1;
    end
`endif
    if (was_empty || popped) m_cnt = 0;
    else if (m_cnt < int'(STARVE_MAX)) m_cnt++;
    if (acc && mdu_wn != 0 && !byp) begin
      e.wn = mdu_wn; e.d = mdu_d;
      mq.push_back(e);
    end
  endtask

  task automatic check_model(input string tag);
    bit ha = 1'b0, hb = 1'b0;
    foreach (mq[i]) begin
      if (rna != 0 && mq[i].wn == rna) ha = 1'b1;
      if (rnb != 0 && mq[i].wn == rnb) hb = 1'b1;
    end
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(m_we));
    if (m_we) begin
      chk({tag, ".rf_wn"}, 32'(rf_wn), 32'(m_wn));
      chk({tag, ".rf_d"}, rf_d, m_d);
    end
    chk({tag, ".level"}, 32'(level), 32'(mq.size()));
    chk({tag, ".mdu_ready"}, 32'(mdu_ready), 32'(mq.size() < int'(DEPTH)));
    chk({tag, ".drain_req"}, 32'(drain_req), 32'(m_cnt == int'(STARVE_MAX)));
    chk({tag, ".hz_a"}, 32'(hz_a), 32'(ha));
    chk({tag, ".hz_b"}, 32'(hz_b), 32'(hb));
  endtask

  // Called at posedge+1; asserts reset off the clock edge.
  task automatic do_reset();
    #1 clrn = 1'b0;
    idle();
    model_clear();
    @(negedge clk);
    clrn = 1'b1;
    tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic alu_we; logic [4:0] alu_wn; logic [31:0] alu_d;
    logic mdu_valid; logic [4:0] mdu_wn; logic [31:0] mdu_d;
    logic [4:0] rna, rnb;
    logic e_we; logic [4:0] e_wn; logic [31:0] e_d;
    logic [LVL_W-1:0] e_level; logic e_ready, e_hza, e_hzb;
  } vec_t;

  function automatic vec_t mk(input logic aw, input logic [4:0] awn, input logic [31:0] ad,
                              input logic mv, input logic [4:0] mwn, input logic [31:0] md,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic ewe, input logic [4:0] ewn, input logic [31:0] ed,
                              input logic [LVL_W-1:0] elv, input logic erdy,
                              input logic eha, input logic ehb);
    vec_t v;
    v.alu_we = aw; v.alu_wn = awn; v.alu_d = ad;
    v.mdu_valid = mv; v.mdu_wn = mwn; v.mdu_d = md;
    v.rna = ra; v.rnb = rb;
    v.e_we = ewe; v.e_wn = ewn; v.e_d = ed;
    v.e_level = elv; v.e_ready = erdy; v.e_hza = eha; v.e_hzb = ehb;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    clrn = 1'b0;
    idle();
    model_clear();

    // Reset state, sampled mid-reset with an empty FIFO and nonzero sources.
    rna = 5'd5; rnb = 5'd6;
    #7;
    chk("reset.rf_we", 32'(rf_we), 32'd0);
    chk("reset.rf_wn", 32'(rf_wn), 32'd0);
    chk("reset.rf_d", rf_d, 32'd0);
    chk("reset.level", 32'(level), 32'd0);
    chk("reset.mdu_ready", 32'(mdu_ready), 32'd1);
    chk("reset.drain_req", 32'(drain_req), 32'd0);
    chk("reset.hz_a", 32'(hz_a), 32'd0);
    chk("reset.hz_b", 32'(hz_b), 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    idle();
    tick();

    //          alu we/wn/d        mdu v/wn/d        rna rnb  exp we/wn/d        lvl rdy hza hzb
    tbl[0]  = mk(1, 3,  32'h11, 1, 5, 32'h55, 0, 0, 1, 3,  32'h11, 1, 1, 0, 0);
    tbl[1]  = mk(1, 4,  32'h22, 1, 6, 32'h66, 5, 6, 1, 4,  32'h22, 2, 1, 1, 1);
    tbl[2]  = mk(1, 1,  32'h33, 1, 7, 32'h77, 7, 0, 1, 1,  32'h33, 3, 1, 1, 0);
    tbl[3]  = mk(1, 2,  32'h44, 1, 8, 32'h88, 8, 9, 1, 2,  32'h44, 4, 0, 1, 0);
    tbl[4]  = mk(0, 0,  32'h0,  1, 9, 32'h99, 5, 8, 1, 5,  32'h55, 3, 1, 0, 1);
    tbl[5]  = mk(0, 0,  32'h0,  0, 0, 32'h0,  6, 7, 1, 6,  32'h66, 2, 1, 0, 1);
    tbl[6]  = mk(0, 0,  32'h0,  0, 0, 32'h0,  8, 7, 1, 7,  32'h77, 1, 1, 1, 0);
    tbl[7]  = mk(0, 0,  32'h0,  0, 0, 32'h0,  8, 0, 1, 8,  32'h88, 0, 1, 0, 0);
    tbl[8]  = mk(0, 0,  32'h0,  0, 0, 32'h0,  0, 0, 0, 0,  32'h0,  0, 1, 0, 0);
    tbl[9]  = mk(1, 0,  32'h77, 1, 0, 32'hA8, 0, 0, 0, 0,  32'h0,  0, 1, 0, 0);
    tbl[10] = mk(1, 10, 32'h0A, 1, 9, 32'h99, 9, 0, 1, 10, 32'h0A, 1, 1, 1, 0);
    tbl[11] = mk(1, 11, 32'h0B, 0, 0, 32'h0,  0, 9, 1, 11, 32'h0B, 1, 1, 0, 1);
    tbl[12] = mk(0, 0,  32'h0,  0, 0, 32'h0,  9, 9, 1, 9,  32'h99, 0, 1, 0, 0);

    for (int i = 0; i < 13; i++) begin
      alu_we = tbl[i].alu_we; alu_wn = tbl[i].alu_wn; alu_d = tbl[i].alu_d;
      mdu_valid = tbl[i].mdu_valid; mdu_wn = tbl[i].mdu_wn; mdu_d = tbl[i].mdu_d;
      rna = tbl[i].rna; rnb = tbl[i].rnb;
      tick();
      chk($sformatf("vec%0d.rf_we", i), 32'(rf_we), 32'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk($sformatf("vec%0d.rf_wn", i), 32'(rf_wn), 32'(tbl[i].e_wn));
        chk($sformatf("vec%0d.rf_d", i), rf_d, tbl[i].e_d);
      end
      chk($sformatf("vec%0d.level", i), 32'(level), 32'(tbl[i].e_level));
      chk($sformatf("vec%0d.mdu_ready", i), 32'(mdu_ready), 32'(tbl[i].e_ready));
      chk($sformatf("vec%0d.hz_a", i), 32'(hz_a), 32'(tbl[i].e_hza));
      chk($sformatf("vec%0d.hz_b", i), 32'(hz_b), 32'(tbl[i].e_hzb));
      chk($sformatf("vec%0d.drain_req", i), 32'(drain_req), 32'd0);
    end

    // Starvation: queue one entry behind an ALU write, then block it.
    idle();
    alu_we = 1'b1; alu_wn = 5'd1; alu_d = 32'h1;
    mdu_valid = 1'b1; mdu_wn = 5'd12; mdu_d = 32'hC0;
    tick();
    chk("starve.level", 32'(level), 32'd1);
    mdu_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      alu_we = 1'b1; alu_wn = 5'd2; alu_d = 32'(i);
      tick();
      chk($sformatf("starve%0d.drain_req", i), 32'(drain_req), 32'(i >= 7));
      chk($sformatf("starve%0d.rf_wn", i), 32'(rf_wn), 32'd2);
    end
    idle();
    tick();
    chk("drain.rf_we", 32'(rf_we), 32'd1);
    chk("drain.rf_wn", 32'(rf_wn), 32'd12);
    chk("drain.rf_d", rf_d, 32'hC0);
    chk("drain.drain_req", 32'(drain_req), 32'd0);
    chk("drain.level", 32'(level), 32'd0);

    // Reset with three entries queued.
    for (int i = 0; i < 3; i++) begin
      alu_we = 1'b1; alu_wn = 5'd1; alu_d = 32'h5;
      mdu_valid = 1'b1; mdu_wn = 5'(20 + i); mdu_d = 32'(i);
      tick();
    end
    chk("pre_rst.level", 32'(level), 32'd3);
    idle();
    #1 clrn = 1'b0;
    #1;
    chk("mid_rst.level", 32'(level), 32'd0);
    chk("mid_rst.mdu_ready", 32'(mdu_ready), 32'd1);
    chk("mid_rst.rf_we", 32'(rf_we), 32'd0);
    chk("mid_rst.drain_req", 32'(drain_req), 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst%0d.rf_we", i), 32'(rf_we), 32'd0);
      chk($sformatf("post_rst%0d.level", i), 32'(level), 32'd0);
    end

    // MDU beat into an empty FIFO with no ALU write.
    mdu_valid = 1'b1; mdu_wn = 5'd13; mdu_d = 32'hD0;
    tick();
    idle();
`ifdef PIPE_WB_QUEUE_BYPASS_EN
    chk("bypass.rf_we", 32'(rf_we), 32'd1);
    chk("bypass.rf_wn", 32'(rf_wn), 32'd13);
    chk("bypass.rf_d", rf_d, 32'hD0);
    chk("bypass.level", 32'(level), 32'd0);
    tick();
    chk("bypass2.rf_we", 32'(rf_we), 32'd0);
`else
    chk("mdu_lat1.rf_we", 32'(rf_we), 32'd0);
    chk("mdu_lat1.level", 32'(level), 32'd1);
    tick();
    chk("mdu_lat2.rf_we", 32'(rf_we), 32'd1);
    chk("mdu_lat2.rf_wn", 32'(rf_wn), 32'd13);
    chk("mdu_lat2.rf_d", rf_d, 32'hD0);
    chk("mdu_lat2.level", 32'(level), 32'd0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit hold;
      if (i == 1500) do_reset();
      hold = ((i / 40) % 5) == 4;
      alu_we = hold ? 1'b1 : ($urandom_range(0, 99) < 40);
      alu_wn = hold ? 5'($urandom_range(1, 7)) : 5'($urandom_range(0, 7));
      alu_d = $urandom;
      mdu_valid = ($urandom_range(0, 99) < 60);
      mdu_wn = 5'($urandom_range(0, 7));
      mdu_d = $urandom;
      rna = 5'($urandom_range(0, 7));
      rnb = 5'($urandom_range(0, 7));
      model_step();
      tick();
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
